// File: rtl/trace_frame_capture_pkg.sv
// -----------------------------------------------------------------------------
// traceCapPkg
// Shared definitions for the trace frame capture block:
//   SYNC_WORD            : 32-bit TPIU full-word synchronisation pattern
//   width_sel_e          : encodings of the trace-port width selector
//   DEFAULT_FRAME_BYTES  : default TPIU frame length in bytes
//   width_bits()         : number of pins consumed per trace edge for a mode
// -----------------------------------------------------------------------------
package traceCapPkg;

    // Bytes FF FF FF 7F on the wire, LSB-first, oldest bit in window bit 0.
    localparam logic [31:0] SYNC_WORD = 32'h7FFF_FFFF;

    localparam int DEFAULT_FRAME_BYTES = 16;

    typedef enum logic [1:0] {
        WSEL_1BIT = 2'd0,
        WSEL_2BIT = 2'd1,
        WSEL_4BIT = 2'd2,
        WSEL_RSVD = 2'd3
    } width_sel_e;

    // Pins consumed per trace edge; the reserved code behaves as 4-bit mode.
    function automatic logic [2:0] width_bits(input logic [1:0] sel);
        logic [2:0] n;
        case (width_sel_e'(sel))
            WSEL_1BIT: n = 3'd1;
            WSEL_2BIT: n = 3'd2;
            WSEL_4BIT: n = 3'd4;
            default:   n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/trace_frame_capture_frame_fifo.sv
// -----------------------------------------------------------------------------
// frame_fifo
// First-word fall-through queue of completed trace frames.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset (empties queue, clears storage)
//   push       : write request for push_data
//   push_data  : frame to enqueue
//   pop        : remove head entry (ignored when empty)
//   head_data  : oldest entry, valid whenever empty=0
//   full/empty : occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module frame_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Occupancy flags and accepted push/pop qualifiers.
    always_comb begin
        full_s    = (count_r == DEPTH_C);
        empty_s   = (count_r == {CW{1'b0}});
        pop_ok_s  = pop && !empty_s;
        push_ok_s = push && (!full_s || pop_ok_s);
    end

    // Storage, pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign full      = full_s;
    assign empty     = empty_s;

endmodule

// File: rtl/trace_frame_capture.sv
// -----------------------------------------------------------------------------
// trace_frame_capture
// Captures TPIU trace frames from a 1/2/4-pin trace port sample stream.
// Ports:
//   clk, rstn   : clock and asynchronous active-low reset
//   widthSel    : port width mode (0=1 bit, 1=2 bits, 2/3=4 bits)
//   edgeValid   : one trace edge sampled this cycle
//   edgeData    : pin sample for that edge, bit 0 earliest in the stream
//   frameData   : head frame of the output queue, byte 0 in [7:0]
//   frameValid  : frameData holds a frame
//   frameReady  : consumer takes the frame this cycle
//   synced      : sync pattern seen since reset / last width change
//   overflow    : sticky, a completed frame was dropped
//   dropCount   : saturating count of dropped frames
// Every consumed bit is shifted through a 32-bit sync window and checked
// for the sync word before being appended to the frame, so a sync at any
// bit offset inside an edge restarts framing with the very next bit.
// -----------------------------------------------------------------------------
module trace_frame_capture
    import traceCapPkg::*;
#(
    parameter int MAX_WIDTH   = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int FRAME_BYTES = DEFAULT_FRAME_BYTES
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [1:0]               widthSel,
    input  logic                     edgeValid,
    input  logic [MAX_WIDTH-1:0]     edgeData,
    output logic [8*FRAME_BYTES-1:0] frameData,
    output logic                     frameValid,
    input  logic                     frameReady,
    output logic                     synced,
    output logic                     overflow,
    output logic [7:0]               dropCount
);

    localparam int FRAME_BITS = 8 * FRAME_BYTES;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT_C = CNT_W'(FRAME_BITS - 1);

    logic                  run_r;
    logic [1:0]            width_q_r;
    logic                  synced_r;
    logic [31:0]           window_r;
    logic [FRAME_BITS-1:0] acc_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  overflow_r;
    logic [7:0]            drop_cnt_r;

    logic [2:0]            nbits_s;
    logic                  width_chg_s;
    logic                  synced_nxt_s;
    logic [31:0]           window_nxt_s;
    logic [FRAME_BITS-1:0] acc_nxt_s;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic                  push_s;
    logic [FRAME_BITS-1:0] push_data_s;
    logic                  pop_s;
    logic                  drop_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [FRAME_BITS-1:0] head_data_s;

    // Reset release synchroniser: logic runs from the first edge after rstn rises.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Bit-serial sync search and frame assembly for up to MAX_WIDTH bits per edge.
    always_comb begin
        nbits_s      = width_bits(width_q_r);
        width_chg_s  = run_r && (widthSel != width_q_r);
        synced_nxt_s = synced_r;
        window_nxt_s = window_r;
        acc_nxt_s    = acc_r;
        cnt_nxt_s    = cnt_r;
        push_s       = 1'b0;
        push_data_s  = {FRAME_BITS{1'b0}};
        if (!run_r) begin
            synced_nxt_s = synced_r;
        end else if (width_chg_s) begin
            // A new port width invalidates any alignment; the edge of this
            // cycle is not consumed.
            synced_nxt_s = 1'b0;
            window_nxt_s = 32'h0000_0000;
            acc_nxt_s    = {FRAME_BITS{1'b0}};
            cnt_nxt_s    = {CNT_W{1'b0}};
        end else if (edgeValid) begin
            for (int i = 0; i < MAX_WIDTH; i++) begin
                if (i < int'(nbits_s)) begin
                    window_nxt_s = {edgeData[i], window_nxt_s[31:1]};
                    if (window_nxt_s == SYNC_WORD) begin
                        // Sync wins over a frame completing on the same bit.
                        synced_nxt_s = 1'b1;
                        acc_nxt_s    = {FRAME_BITS{1'b0}};
                        cnt_nxt_s    = {CNT_W{1'b0}};
                    end else if (synced_nxt_s) begin
                        // Shift in at the top so the first bit ends in bit 0.
                        acc_nxt_s = {edgeData[i], acc_nxt_s[FRAME_BITS-1:1]};
                        if (cnt_nxt_s == LAST_BIT_C) begin
                            push_s      = 1'b1;
                            push_data_s = acc_nxt_s;
                            acc_nxt_s   = {FRAME_BITS{1'b0}};
                            cnt_nxt_s   = {CNT_W{1'b0}};
                        end else begin
                            cnt_nxt_s = cnt_nxt_s + CNT_W'(1);
                        end
                    end else begin
                        acc_nxt_s = acc_nxt_s;
                    end
                end else begin
                    window_nxt_s = window_nxt_s;
                end
            end
        end else begin
            synced_nxt_s = synced_r;
        end
    end

    // Handshake and drop detection (a pop frees a slot in the same cycle).
    always_comb begin
        pop_s  = !fifo_empty_s && frameReady;
        drop_s = push_s && fifo_full_s && !pop_s;
    end

    // Capture state, sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            width_q_r  <= 2'd0;
            synced_r   <= 1'b0;
            window_r   <= 32'h0000_0000;
            acc_r      <= {FRAME_BITS{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else begin
            width_q_r <= widthSel;
            synced_r  <= synced_nxt_s;
            window_r  <= window_nxt_s;
            acc_r     <= acc_nxt_s;
            cnt_r     <= cnt_nxt_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != 8'hFF) begin
                    drop_cnt_r <= drop_cnt_r + 8'd1;
                end
            end
        end
    end

    frame_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_frame_fifo (
        .clk       (clk),
        .rst_n     (rstn),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head_data (head_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign frameData  = head_data_s;
    assign frameValid = !fifo_empty_s;
    assign synced     = synced_r;
    assign overflow   = overflow_r;
    assign dropCount  = drop_cnt_r;

endmodule

// File: tb/tb_trace_frame_capture.sv
module tb_trace_frame_capture;

    localparam int FBITS = 128;
    localparam int DEPTH = 4;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [1:0]   wsel;
        int           nbytes;
        logic [319:0] stream;
        int           exp_frames;
        logic [127:0] exp_frame;
        logic         exp_synced;
    } vec_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [1:0]   widthSel = 2'd2;
    logic         edgeValid = 1'b0;
    logic [3:0]   edgeData = 4'd0;
    logic [127:0] frameData;
    logic         frameValid;
    logic         frameReady = 1'b0;
    logic         synced;
    logic         overflow;
    logic [7:0]   dropCount;

    int checks = 0;
    int errors = 0;
    int ready_mode = 1;

    // reference model: bit-stream level view of the capture rules
    logic [31:0]  m_win;
    bit           m_synced;
    bit           m_part[$];
    logic [127:0] m_q[$];
    bit           m_ovf;
    int           m_drop;
    logic [1:0]   m_wprev;
    logic [127:0] got[$];

    always #5 clk = ~clk;

    trace_frame_capture #(.MAX_WIDTH(4), .FIFO_DEPTH(DEPTH), .FRAME_BYTES(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .widthSel   (widthSel),
        .edgeValid  (edgeValid),
        .edgeData   (edgeData),
        .frameData  (frameData),
        .frameValid (frameValid),
        .frameReady (frameReady),
        .synced     (synced),
        .overflow   (overflow),
        .dropCount  (dropCount)
    );

    function automatic int wbits(input logic [1:0] w);
        case (w)
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset(input logic [1:0] w);
        m_win = 32'd0;
        m_synced = 1'b0;
        m_part.delete();
        m_q.delete();
        m_ovf = 1'b0;
        m_drop = 0;
        m_wprev = w;
    endtask

    task automatic model_edge(input bit ev, input logic [3:0] data, input bit ready);
        bit pop;
        bit done;
        logic [127:0] fr;
        pop = (m_q.size() > 0) && ready;
        done = 1'b0;
        fr = '0;
        if (widthSel != m_wprev) begin
            m_wprev = widthSel;
            m_win = 32'd0;
            m_synced = 1'b0;
            m_part.delete();
        end else if (ev) begin
            for (int i = 0; i < wbits(widthSel); i++) begin
                m_win = {data[i], m_win[31:1]};
                if (m_win == 32'h7FFF_FFFF) begin
                    m_synced = 1'b1;
                    m_part.delete();
                end else if (m_synced) begin
                    m_part.push_back(data[i]);
                    if (m_part.size() == FBITS) begin
                        for (int k = 0; k < FBITS; k++) fr[k] = m_part[k];
                        m_part.delete();
                        done = 1'b1;
                    end
                end
            end
        end
        if (pop) void'(m_q.pop_front());
        if (done) begin
            if (m_q.size() < DEPTH) m_q.push_back(fr);
            else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
    endtask

    // one clock: drive, record handshake, advance model, compare after the edge
    task automatic step(input bit ev, input logic [3:0] data);
        bit rdy;
        case (ready_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        edgeValid = ev;
        edgeData = data;
        frameReady = rdy;
        if (frameValid && rdy) got.push_back(frameData);
        @(posedge clk);
        model_edge(ev, data, rdy);
        #1;
        check("status", {frameValid, synced, overflow, dropCount},
              {(m_q.size() != 0), m_synced, m_ovf, m_drop[7:0]});
        if (m_q.size() > 0) check("head_data", frameData, m_q[0]);
    endtask

    task automatic apply_reset(input logic [1:0] w);
        rstn = 1'b0;
        edgeValid = 1'b0;
        widthSel = w;
        #1;
        check("rst_outputs", {frameValid, synced, overflow, dropCount}, 128'd0);
        check("rst_data", frameData, 128'd0);
        got.delete();
        model_reset(w);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(1'b0, 4'd0);
    endtask

    task automatic send_bytes(input bq_t b);
        bit bq[$];
        int w;
        logic [3:0] d;
        foreach (b[j]) for (int k = 0; k < 8; k++) bq.push_back(b[j][k]);
        w = wbits(widthSel);
        while (bq.size() > 0) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 4'($urandom));
            d = 4'($urandom);
            for (int i = 0; i < w; i++) d[i] = bq.pop_front();
            step(1'b1, d);
        end
    endtask

    task automatic send_sync();
        bq_t q;
        q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
        send_bytes(q);
    endtask

    task automatic send_packed(input logic [319:0] v, input int n);
        bq_t q;
        for (int k = 0; k < n; k++) q.push_back(v[8*k +: 8]);
        send_bytes(q);
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, 4'($urandom));
    endtask

    function automatic logic [127:0] rnd_frame();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        logic [127:0] frame_a;
        logic [63:0]  sync64;
        logic [63:0]  half;
        logic [127:0] f[5];
        logic [127:0] fb;

        frame_a = 128'hEFCD_AB89_6745_2301_EFCD_AB89_6745_2301;
        sync64  = 64'h7FFF_FFFF_FFFF_FFFF;
        half    = 64'h9966_9966_55AA_55AA;
        for (int t = 0; t < 4; t++) begin
            vecs[t].wsel = 2'(t);
            vecs[t].nbytes = 24;
            vecs[t].stream = {128'd0, frame_a, sync64};
            vecs[t].exp_frames = 1;
            vecs[t].exp_frame = frame_a;
            vecs[t].exp_synced = 1'b1;
        end
        for (int t = 4; t < 6; t++) begin
            vecs[t].wsel = (t == 4) ? 2'd2 : 2'd0;
            vecs[t].nbytes = 8;
            vecs[t].stream = {256'd0, half};
            vecs[t].exp_frames = 0;
            vecs[t].exp_frame = 128'd0;
            vecs[t].exp_synced = 1'b0;
        end

        // table: same stream in every width, and an unsynced half frame
        for (int t = 0; t < 6; t++) begin
            apply_reset(vecs[t].wsel);
            ready_mode = 1;
            send_packed(vecs[t].stream, vecs[t].nbytes);
            drain(6);
            check($sformatf("vec%0d_count", t), got.size(), vecs[t].exp_frames);
            if (got.size() > 0 && vecs[t].exp_frames > 0)
                check($sformatf("vec%0d_frame", t), got[0], vecs[t].exp_frame);
            check($sformatf("vec%0d_synced", t), synced, vecs[t].exp_synced);
            check($sformatf("vec%0d_valid", t), frameValid, 1'b0);
        end

        // resync before first frame completes
        apply_reset(2'd2);
        fb = rnd_frame();
        send_sync();
        send_bytes({8'h01, 8'h23});
        send_sync();
        send_packed({192'd0, fb}, 16);
        drain(6);
        check("resync_count", got.size(), 1);
        if (got.size() > 0) check("resync_frame", got[0], fb);
        check("resync_drop", dropCount, 8'd0);

        // overflow: five frames into a four-deep queue
        apply_reset(2'd1);
        ready_mode = 0;
        send_sync();
        for (int k = 0; k < 5; k++) begin
            f[k] = rnd_frame();
            send_packed({192'd0, f[k]}, 16);
        end
        drain(2);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_count", dropCount, 8'd1);
        widthSel = 2'd2;
        step(1'b0, 4'd0);
        check("ovf_kept_on_width", {overflow, dropCount}, {1'b1, 8'd1});
        ready_mode = 1;
        drain(10);
        check("ovf_delivered", got.size(), 4);
        for (int k = 0; k < 4; k++)
            if (got.size() > k) check($sformatf("ovf_order%0d", k), got[k], f[k]);

        // reset mid-frame with a queued frame, then sync plus frame
        apply_reset(2'd2);
        ready_mode = 0;
        send_sync();
        send_packed({192'd0, rnd_frame()}, 16);
        send_bytes({8'h11, 8'h22, 8'h33});
        apply_reset(2'd2);
        ready_mode = 1;
        fb = rnd_frame();
        send_sync();
        send_packed({192'd0, fb}, 16);
        drain(6);
        check("rst_mid_count", got.size(), 1);
        if (got.size() > 0) check("rst_mid_frame", got[0], fb);

        // width change mid-frame
        apply_reset(2'd2);
        send_sync();
        send_bytes({8'h01, 8'h23, 8'h45, 8'h67, 8'h89});
        widthSel = 2'd0;
        step(1'b0, 4'd0);
        check("wchg_synced", synced, 1'b0);
        fb = rnd_frame();
        send_sync();
        send_packed({192'd0, fb}, 16);
        drain(6);
        check("wchg_count", got.size(), 1);
        if (got.size() > 0) check("wchg_frame", got[0], fb);

        // randomized traffic against the model
        apply_reset(2'($urandom_range(0, 3)));
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 6))
                0: send_sync();
                1, 2: send_packed({192'd0, rnd_frame()}, 16);
                3: begin
                    bq_t q;
                    int n;
                    n = $urandom_range(1, 20);
                    for (int k = 0; k < n; k++) q.push_back(8'($urandom));
                    send_bytes(q);
                end
                4: begin
                    widthSel = 2'($urandom_range(0, 3));
                    step(1'b0, 4'd0);
                end
                5: ready_mode = $urandom_range(0, 2);
                default: if ($urandom_range(0, 3) == 0) apply_reset(2'($urandom_range(0, 3)));
                         else send_sync();
            endcase
        end
        ready_mode = 1;
        drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_frame_capture.md
TRACE_FRAME_CAPTURE -- requirements
Module: trace_frame_capture

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 4, maximum trace port pins supported.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), completed-frame queue depth.
REQ-003 SHALL have parameter FRAME_BYTES, default 16, TPIU frame length in bytes.
REQ-004 SHALL have ports, one per line:
- clk  in  1  single system clock; all logic on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- widthSel  in  2  trace width mode: 0=1 bit, 1=2 bits, 2=4 bits, 3=reserved (treated as 4).
- edgeValid  in  1  one-cycle strobe: one trace clock edge sampled.
- edgeData  in  MAX_WIDTH  pin sample for that edge; bit 0 is the earliest stream bit.
- frameData  out  8*FRAME_BYTES  frame output; byte 0 in [7:0], LSB-first.
- frameValid  out  1  frameData holds a frame.
- frameReady  in  1  consumer accepts the frame.
- synced  out  1  a sync pattern has been seen since reset or mode change.
- overflow  out  1  sticky: a frame was dropped.
- dropCount  out  8  saturating count of dropped frames.

Function
REQ-005 SHALL consume only the low W bits of edgeData per edgeValid, with W = 1, 2 or 4 from widthSel; other cycles SHALL change nothing.
REQ-006 SHALL shift each consumed bit, earliest first, into a 32-bit sync window; a match SHALL occur when the window equals 32'h7FFFFFFF (bytes FF FF FF 7F on the wire).
REQ-007 SHALL test for a match after every individual bit, at all W bit offsets within one edge.
REQ-008 On a match, SHALL set synced, discard any partial frame, and start a new frame with the bit after the match; the remaining bits of the same edge SHALL go into the new frame.
REQ-009 While synced=0, SHALL assemble no frames.
REQ-010 While synced=1, SHALL append bits LSB-first into a 8*FRAME_BYTES accumulator with a bit counter.
REQ-011 When the bit counter reaches 8*FRAME_BYTES, SHALL push the frame into the FIFO and reset the counter; following bits of the same edge SHALL begin the next frame.
REQ-012 Matches SHALL take precedence over frame completion when both occur at the same bit.
REQ-013 SHALL make a frame completed in cycle N visible as frameValid=1 in cycle N+1 when the FIFO was empty (first-word fall-through).
REQ-014 Handshake:
- A frame SHALL leave the FIFO only in a cycle with frameValid&frameReady.
- frameData SHALL stay stable while frameValid=1 and frameReady=0.
REQ-015 Completion with the FIFO full:
- If no pop occurs in the same cycle, SHALL drop the new frame, set overflow, and increment dropCount, saturating at 255.
- If a pop occurs in the same cycle, SHALL accept the frame.
REQ-016 A change of widthSel SHALL, in the next cycle:
- clear synced, the sync window and the partial frame;
- leave FIFO contents, overflow and dropCount intact.
REQ-017 overflow and dropCount SHALL clear only on reset.

Reset
REQ-018 With rstn=0, SHALL asynchronously force:
- frameValid=0, synced=0, overflow=0, dropCount=0, frameData=0;
- FIFO empty, sync window=0, bit counter=0.
REQ-019 Deassertion SHALL be synchronised to clk; the first edgeValid accepted SHALL be the one in the cycle after rstn rises.
REQ-020 Reset mid-frame SHALL discard the partial frame and all queued frames.

Structure
REQ-021 A shared package traceCapPkg SHALL hold:
- the SYNC_WORD constant 32'h7FFFFFFF;
- the widthSel encodings;
- the default FRAME_BYTES.
REQ-022 The queue SHALL be one sub-module, frame_fifo (parametrised width/depth, FWFT, full/empty, async active-low reset); all other logic SHALL be in trace_frame_capture.

Verification
REQ-023 Frame in 4-bit mode:
- Stimulus: width 4; bytes FF x7, 7F; then 01 23 45 67 89 AB CD EF twice; frameReady=1.
- Response: one frame, 0xEFCDAB8967452301EFCDAB8967452301; synced=1.
REQ-024 Same stream in 1-bit and 2-bit modes SHALL give the identical frame.
REQ-025 Sync before the first frame is complete:
- Stimulus: sync; 01 23; sync; full frame.
- Response: exactly one frame out, equal to the full frame; partial frame discarded; dropCount=0.
REQ-026 Overflow:
- Stimulus: frameReady=0; sync; 5 frames; then frameReady=1.
- Response: 4 frames delivered in order; overflow=1; dropCount=1.
REQ-027 Half-frame of AA 55 AA 55 66 99 66 99 before any sync SHALL give no frameValid and synced=0.
REQ-028 Reset or widthSel change mid-frame, then sync plus frame SHALL give only the post-event frame.
